serial_word_rx: RTL and testbench

Serial-to-parallel word receiver. Collects a framed serial bit stream, one bit per strobe, into WIDTH-bit words and presents each completed word on a parallel output with a valid/ready handshake. It sits on the receiving end of the shift-register serial outputs, so a 4-bit register shifted out bit by bit arrives here as one 4-bit word. A holding register decouples word assembly from the consumer and reports overrun when the consumer stalls.

---
 rtl/usr_pkg.sv | 8 +
 rtl/serial_word_rx.sv | 127 ++++++++++++
 tb/tb_serial_word_rx.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared types and defaults for the serial word receiver.
package usr_pkg;

    typedef enum logic {IDLE, SHIFT} rx_state_t;

    localparam int unsigned DefaultWidth = 4;

endpackage

// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver: assembles framed serial bits into words and
// presents them through a single holding register with a valid/ready handshake.
module serial_word_rx
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_din,
    input  logic             s_valid,
    input  logic             s_frame,
    output logic [WIDTH-1:0] p_dout,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    rx_state_t        state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] p_dout_q, p_dout_d;
    logic             p_valid_q, p_valid_d;
    logic             overrun_q, overrun_d;
    logic             frame_err_q, frame_err_d;

    logic [WIDTH-1:0] sh_shifted;
    logic [WIDTH-1:0] sh_first;
    logic             word_done;

    // The first bit is placed where subsequent shifts will carry it to its final position.
    always_comb begin
        if (MSB_FIRST) begin
            sh_shifted = {sh_q[WIDTH-2:0], s_din};
            sh_first   = {{(WIDTH-1){1'b0}}, s_din};
        end else begin
            sh_shifted = {s_din, sh_q[WIDTH-1:1]};
            sh_first   = {s_din, {(WIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        state_d     = state_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        frame_err_d = 1'b0;
        word_done   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (s_valid && s_frame) begin
                    sh_d    = sh_first;
                    cnt_d   = CntW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (s_valid && s_frame) begin
                    sh_d        = sh_first;
                    cnt_d       = CntW'(1);
                    frame_err_d = 1'b1;
                end else if (s_valid) begin
                    sh_d = sh_shifted;
                    if (cnt_q == LastCnt) begin
                        word_done = 1'b1;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A completed word may replace the held one only if the held one leaves this same cycle.
    always_comb begin
        p_dout_d  = p_dout_q;
        p_valid_d = p_valid_q;
        overrun_d = 1'b0;

        if (word_done) begin
            if (!p_valid_q || p_ready) begin
                p_dout_d  = sh_shifted;
                p_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (p_valid_q && p_ready) begin
            p_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sh_q        <= '0;
            cnt_q       <= '0;
            p_dout_q    <= '0;
            p_valid_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            p_dout_q    <= p_dout_d;
            p_valid_q   <= p_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign p_dout    = p_dout_q;
    assign p_valid   = p_valid_q;
    assign busy      = (state_q == SHIFT);
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_word_rx.sv
// Self-checking bench: an MSB-first and an LSB-first receiver share one stimulus stream,
// and a scoreboard queue per instance holds the words each one must deliver.
module tb_serial_word_rx;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         s_din;
    logic         s_valid;
    logic         s_frame;
    logic         p_ready;
    logic [W-1:0] p_dout_m, p_dout_l;
    logic         p_valid_m, p_valid_l;
    logic         busy_m, busy_l;
    logic         overrun_m, overrun_l;
    logic         frame_err_m, frame_err_l;

    int n_tests;
    int n_fail;
    int ovr_cnt;
    int ferr_cnt;
    logic [W-1:0] q_m[$];
    logic [W-1:0] q_l[$];

    serial_word_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut_msb (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_din     (s_din),
        .s_valid   (s_valid),
        .s_frame   (s_frame),
        .p_dout    (p_dout_m),
        .p_valid   (p_valid_m),
        .p_ready   (p_ready),
        .busy      (busy_m),
        .overrun   (overrun_m),
        .frame_err (frame_err_m)
    );

    serial_word_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_dut_lsb (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_din     (s_din),
        .s_valid   (s_valid),
        .s_frame   (s_frame),
        .p_dout    (p_dout_l),
        .p_valid   (p_valid_l),
        .p_ready   (p_ready),
        .busy      (busy_l),
        .overrun   (overrun_l),
        .frame_err (frame_err_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    // Mid-cycle: a word shown with p_ready high is consumed at the coming edge.
    task automatic monitor();
        if (overrun_m) ovr_cnt++;
        if (frame_err_m) ferr_cnt++;
        if (p_valid_m && p_ready) begin
            if (q_m.size() == 0) check_eq("msb_sb_empty", 32'(q_m.size()), 32'd1);
            else check_eq("msb_word", 32'(p_dout_m), 32'(q_m.pop_front()));
        end
        if (p_valid_l && p_ready) begin
            if (q_l.size() == 0) check_eq("lsb_sb_empty", 32'(q_l.size()), 32'd1);
            else check_eq("lsb_word", 32'(p_dout_l), 32'(q_l.pop_front()));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        s_frame = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send_bit(input logic din, input logic frame);
        s_din   = din;
        s_frame = frame;
        s_valid = 1'b1;
        cycle();
        s_valid = 1'b0;
        s_frame = 1'b0;
    endtask

    // Word bits go out MSB of w first; the LSB-first receiver therefore sees rev(w).
    task automatic send_word(input logic [W-1:0] w, input bit push, input bit gaps);
        if (push) begin
            q_m.push_back(w);
            q_l.push_back(rev(w));
        end
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(w[i], i == W - 1);
            if (gaps && i > 0) idle(W - 1 - i);
        end
    endtask

    initial begin
        int ovr0;
        int ferr0;
        n_tests  = 0;
        n_fail   = 0;
        ovr_cnt  = 0;
        ferr_cnt = 0;
        rst_n    = 1'b0;
        s_din    = 1'b0;
        s_valid  = 1'b0;
        s_frame  = 1'b0;
        p_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_p_dout", 32'(p_dout_m), 32'h0);
        check_eq("rst_p_valid", 32'(p_valid_m), 32'h0);
        check_eq("rst_busy", 32'(busy_m), 32'h0);
        check_eq("rst_overrun", 32'(overrun_m), 32'h0);
        check_eq("rst_frame_err", 32'(frame_err_m), 32'h0);
        rst_n = 1'b1;
        cycle();

        // 1 & 2: bits 1,0,1,1 -> 0xB MSB-first, 0xD LSB-first
        q_m.push_back(4'hB);
        q_l.push_back(4'hD);
        send_bit(1'b1, 1'b1);
        check_eq("t1_busy_b1", 32'(busy_m), 32'h1);
        send_bit(1'b0, 1'b0);
        check_eq("t1_busy_b2", 32'(busy_m), 32'h1);
        send_bit(1'b1, 1'b0);
        check_eq("t1_busy_b3", 32'(busy_m), 32'h1);
        check_eq("t1_valid_early", 32'(p_valid_m), 32'h0);
        send_bit(1'b1, 1'b0);
        check_eq("t1_busy_b4", 32'(busy_m), 32'h0);
        check_eq("t1_valid", 32'(p_valid_m), 32'h1);
        check_eq("t1_dout", 32'(p_dout_m), 32'hB);
        check_eq("t2_dout_lsb", 32'(p_dout_l), 32'hD);
        cycle();
        check_eq("t1_valid_clr", 32'(p_valid_m), 32'h0);
        idle(2);

        // 3: back-to-back words with consumer stalled
        p_ready = 1'b0;
        ovr0    = ovr_cnt;
        send_word(4'hA, 1'b1, 1'b0);
        check_eq("t3_overrun_none", 32'(overrun_m), 32'h0);
        send_word(4'h5, 1'b0, 1'b0);
        check_eq("t3_overrun", 32'(overrun_m), 32'h1);
        check_eq("t3_overrun_lsb", 32'(overrun_l), 32'h1);
        check_eq("t3_hold", 32'(p_dout_m), 32'hA);
        cycle();
        check_eq("t3_overrun_clr", 32'(overrun_m), 32'h0);
        check_eq("t3_ovr_count", 32'(ovr_cnt - ovr0), 32'd1);
        check_eq("t3_hold2", 32'(p_dout_m), 32'hA);
        p_ready = 1'b1;
        cycle();
        check_eq("t3_valid_clr", 32'(p_valid_m), 32'h0);
        idle(2);

        // 4: restart at bit 3 of a word
        ferr0 = ferr_cnt;
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_word(4'hC, 1'b1, 1'b0);
        cycle();
        check_eq("t4_ferr_count", 32'(ferr_cnt - ferr0), 32'd1);
        check_eq("t4_ferr_clr", 32'(frame_err_m), 32'h0);
        idle(2);

        // 5: stray bits in IDLE, then a word with gaps between bits
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check_eq("t5_stray_busy", 32'(busy_m), 32'h0);
        check_eq("t5_stray_valid", 32'(p_valid_m), 32'h0);
        send_word(4'h9, 1'b1, 1'b1);
        check_eq("t5_dout", 32'(p_dout_m), 32'h9);
        check_eq("t5_dout_lsb", 32'(p_dout_l), 32'h9);
        idle(3);

        // 6: asynchronous reset with a held word and a partial word
        p_ready = 1'b0;
        send_word(4'h3, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(p_valid_m), 32'h0);
        check_eq("t6_rst_dout", 32'(p_dout_m), 32'h0);
        check_eq("t6_rst_busy", 32'(busy_m), 32'h0);
        q_m.delete();
        q_l.delete();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        p_ready = 1'b1;
        cycle();
        send_word(4'h6, 1'b1, 1'b0);
        check_eq("t6_dout", 32'(p_dout_m), 32'h6);
        idle(3);

        check_eq("sb_msb_drained", 32'(q_m.size()), 32'd0);
        check_eq("sb_lsb_drained", 32'(q_l.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
